fu_cdb_arbiter: RTL and testbench

- Owns the shared 2-wide CDB. Arbitrates writeback among the 7 functional units (LDST0/1, MULT0/1, ALU0/1, BR) with rotating priority.
- Each FU gets a one-entry result holding slot, so an FU that loses arbitration can drain later.
- Generates fub_busy for RS issue, so RS never issues to an FU whose result cannot yet be taken.
- Squashes held results on branch mispredict and clears resolved bmask bits on correct prediction.

---
 rtl/fu_cdb_arbiter_pkg.sv | 39 +++
 rtl/fu_cdb_arbiter_pick.sv | 44 ++++
 rtl/fu_cdb_arbiter.sv | 161 ++++++++++++++++
 tb/tb_fu_cdb_arbiter.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fu_cdb_arbiter_pkg.sv
// Shared sizes, FU indices and the per-FU result slot type for the CDB writeback arbiter.
// Pure declarations: no latency and no backpressure of its own.
package fu_cdb_arbiter_pkg;

  localparam int NUM_FU   = 7;
  localparam int CDB_W    = 2;
  localparam int DATA_W   = 64;
  localparam int PHYS_REG = 6;
  localparam int B_MASK   = 4;
  localparam int BS_PTR   = 2;
  localparam int FU_PTR_W = 3;

  localparam int FU_LDST0 = 0;
  localparam int FU_LDST1 = 1;
  localparam int FU_MULT0 = 2;
  localparam int FU_MULT1 = 3;
  localparam int FU_ALU0  = 4;
  localparam int FU_ALU1  = 5;
  localparam int FU_BR    = 6;

  typedef struct packed {
    logic                valid;
    logic [PHYS_REG-1:0] rd;
    logic [DATA_W-1:0]   value;
    logic [B_MASK-1:0]   bmask;
  } cdb_slot_t;

  function automatic logic [FU_PTR_W-1:0] ptr_inc(input logic [FU_PTR_W-1:0] p);
    return (p == FU_PTR_W'(NUM_FU - 1)) ? '0 : p + 1'b1;
  endfunction

  function automatic int unsigned count_ones(input logic [NUM_FU-1:0] v);
    int unsigned c;
    c = 0;
    for (int i = 0; i < NUM_FU; i++) c += int'(v[i]);
    return c;
  endfunction

endpackage

// File: rtl/fu_cdb_arbiter_pick.sv
// rr_pick2: picks the first two requesters scanning from start, wrapping modulo N.
// Purely combinational; no backpressure, the caller decides what a grant means.
module rr_pick2 #(
  parameter int N  = 7,
  parameter int PW = 3
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] start,
  output logic [N-1:0]  gnt0,
  output logic [N-1:0]  gnt1,
  output logic          vld0,
  output logic          vld1,
  output logic [PW-1:0] last_idx
);

  function automatic int wrap(input int s, input int i);
    int t;
    t = s + i;
    if (t >= N) t = t - N;
    return t;
  endfunction

  always_comb begin
    gnt0     = '0;
    gnt1     = '0;
    vld0     = 1'b0;
    vld1     = 1'b0;
    last_idx = start;
    for (int i = 0; i < N; i++) begin
      if (req[wrap(int'(start), i)]) begin
        if (!vld0) begin
          gnt0[wrap(int'(start), i)] = 1'b1;
          vld0                       = 1'b1;
          last_idx                   = PW'(wrap(int'(start), i));
        end else if (!vld1) begin
          gnt1[wrap(int'(start), i)] = 1'b1;
          vld1                       = 1'b1;
          last_idx                   = PW'(wrap(int'(start), i));
        end
      end
    end
  end

endmodule

// File: rtl/fu_cdb_arbiter.sv
// 2-wide CDB writeback arbiter over 7 FU result slots; grant to CDB valid is one cycle.
// Backpressure via fub_busy; optional CDB_PERF_EN adds saturating conflict/squash counters.
module fu_cdb_arbiter
  import fu_cdb_arbiter_pkg::*;
(
  input  logic                             clk,
  input  logic                             reset,
  input  logic [NUM_FU-1:0]                fu_done,
  input  logic [NUM_FU-1:0]                fu_has_dest,
  input  logic [NUM_FU-1:0][PHYS_REG-1:0]  fu_rd,
  input  logic [NUM_FU-1:0][DATA_W-1:0]    fu_value,
  input  logic [NUM_FU-1:0][B_MASK-1:0]    fu_bmask,
  input  logic [NUM_FU-1:0]                fu_inflight,
  input  logic                             br_branch_resolved,
  input  logic                             br_pred_wrong,
  input  logic [BS_PTR-1:0]                br_bs_ptr,
  output logic [CDB_W-1:0]                 cdb_rd_en,
  output logic [CDB_W-1:0][PHYS_REG-1:0]   cdb_rd,
  output logic [CDB_W-1:0][DATA_W-1:0]     cdb_value,
  output logic [NUM_FU-1:0]                fub_busy,
  output logic [NUM_FU-1:0]                fu_grant
`ifdef CDB_PERF_EN
  ,
  output logic [31:0]                      perf_conflict_cycles,
  output logic [31:0]                      perf_squashed
`endif
);

  cdb_slot_t [NUM_FU-1:0] slot_q;
  cdb_slot_t [NUM_FU-1:0] slot_d;
  logic [FU_PTR_W-1:0]    rr_ptr;

  logic                   mispredict;
  logic                   correct;
  logic [NUM_FU-1:0]      slot_valid;
  logic [NUM_FU-1:0]      slot_squash;
  logic [NUM_FU-1:0]      req;
  logic [NUM_FU-1:0]      wr;
  logic [NUM_FU-1:0]      cap_drop;

  logic [NUM_FU-1:0]      gnt0;
  logic [NUM_FU-1:0]      gnt1;
  logic                   vld0;
  logic                   vld1;
  logic [FU_PTR_W-1:0]    last_idx;

  logic [CDB_W-1:0][PHYS_REG-1:0] win_rd;
  logic [CDB_W-1:0][DATA_W-1:0]   win_value;

  assign mispredict = br_branch_resolved & br_pred_wrong;
  assign correct    = br_branch_resolved & ~br_pred_wrong;

  always_comb begin
    slot_valid  = '0;
    slot_squash = '0;
    cap_drop    = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      slot_valid[j]  = slot_q[j].valid;
      slot_squash[j] = mispredict & slot_q[j].valid & slot_q[j].bmask[br_bs_ptr];
      cap_drop[j]    = mispredict & fu_bmask[j][br_bs_ptr];
    end
  end

  // A squashed slot is still occupied this cycle but must never reach the CDB.
  assign req = slot_valid & ~slot_squash;

  rr_pick2 #(
    .N  (NUM_FU),
    .PW (FU_PTR_W)
  ) u_pick (
    .req      (req),
    .start    (rr_ptr),
    .gnt0     (gnt0),
    .gnt1     (gnt1),
    .vld0     (vld0),
    .vld1     (vld1),
    .last_idx (last_idx)
  );

  assign fu_grant = gnt0 | gnt1;
  assign fub_busy = fu_inflight | (slot_valid & ~fu_grant);

  // A slot accepts a new result only if it is empty or draining at this edge.
  assign wr = fu_done & fu_has_dest & (~slot_valid | fu_grant);

  always_comb begin
    slot_d = slot_q;
    for (int j = 0; j < NUM_FU; j++) begin
      if (fu_grant[j] || slot_squash[j]) begin
        slot_d[j].valid = 1'b0;
      end else if (correct) begin
        slot_d[j].bmask[br_bs_ptr] = 1'b0;
      end
      if (wr[j] && !cap_drop[j]) begin
        slot_d[j].valid = 1'b1;
        slot_d[j].rd    = fu_rd[j];
        slot_d[j].value = fu_value[j];
        slot_d[j].bmask = fu_bmask[j];
        if (correct) slot_d[j].bmask[br_bs_ptr] = 1'b0;
      end
    end
  end

  always_comb begin
    win_rd    = '0;
    win_value = '0;
    for (int j = 0; j < NUM_FU; j++) begin
      if (gnt0[j]) begin
        win_rd[0]    = slot_q[j].rd;
        win_value[0] = slot_q[j].value;
      end
      if (gnt1[j]) begin
        win_rd[1]    = slot_q[j].rd;
        win_value[1] = slot_q[j].value;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      slot_q    <= '0;
      rr_ptr    <= '0;
      cdb_rd_en <= '0;
      cdb_rd    <= '0;
      cdb_value <= '0;
    end else begin
      slot_q    <= slot_d;
      cdb_rd_en <= {vld1, vld0};
      if (vld0) begin
        rr_ptr       <= ptr_inc(last_idx);
        cdb_rd[0]    <= win_rd[0];
        cdb_value[0] <= win_value[0];
      end
      // Idle ports keep their last tag/data; only the enable drops.
      if (vld1) begin
        cdb_rd[1]    <= win_rd[1];
        cdb_value[1] <= win_value[1];
      end
    end
  end

  assert property (@(posedge clk) disable iff (reset) !(|(fu_done & slot_valid & ~fu_grant)));

`ifdef CDB_PERF_EN
  logic [32:0] sq_sum;

  assign sq_sum = {1'b0, perf_squashed} + 33'(count_ones(slot_squash | (wr & cap_drop)));

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_conflict_cycles <= '0;
      perf_squashed        <= '0;
    end else begin
      if (count_ones(slot_valid) > 32'(CDB_W) && perf_conflict_cycles != '1)
        perf_conflict_cycles <= perf_conflict_cycles + 32'd1;
      perf_squashed <= sq_sum[32] ? '1 : sq_sum[31:0];
    end
  end
`endif

endmodule

// File: tb/tb_fu_cdb_arbiter.sv
// Directed bench for fu_cdb_arbiter: stimulus pushes expected CDB writes, a negedge monitor pops and compares.
module tb_fu_cdb_arbiter;
  import fu_cdb_arbiter_pkg::*;

  logic                             clk = 1'b0;
  logic                             reset;
  logic [NUM_FU-1:0]                fu_done;
  logic [NUM_FU-1:0]                fu_has_dest;
  logic [NUM_FU-1:0][PHYS_REG-1:0]  fu_rd;
  logic [NUM_FU-1:0][DATA_W-1:0]    fu_value;
  logic [NUM_FU-1:0][B_MASK-1:0]    fu_bmask;
  logic [NUM_FU-1:0]                fu_inflight;
  logic                             br_branch_resolved;
  logic                             br_pred_wrong;
  logic [BS_PTR-1:0]                br_bs_ptr;
  logic [CDB_W-1:0]                 cdb_rd_en;
  logic [CDB_W-1:0][PHYS_REG-1:0]   cdb_rd;
  logic [CDB_W-1:0][DATA_W-1:0]     cdb_value;
  logic [NUM_FU-1:0]                fub_busy;
  logic [NUM_FU-1:0]                fu_grant;

  always #5 clk = ~clk;

  fu_cdb_arbiter dut (
    .clk                (clk),
    .reset              (reset),
    .fu_done            (fu_done),
    .fu_has_dest        (fu_has_dest),
    .fu_rd              (fu_rd),
    .fu_value           (fu_value),
    .fu_bmask           (fu_bmask),
    .fu_inflight        (fu_inflight),
    .br_branch_resolved (br_branch_resolved),
    .br_pred_wrong      (br_pred_wrong),
    .br_bs_ptr          (br_bs_ptr),
    .cdb_rd_en          (cdb_rd_en),
    .cdb_rd             (cdb_rd),
    .cdb_value          (cdb_value),
    .fub_busy           (fub_busy),
    .fu_grant           (fu_grant)
  );

  typedef struct {
    int                  port;
    logic [PHYS_REG-1:0] rd;
    logic [DATA_W-1:0]   value;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   n_cmp  = 0;
  int   n_fail = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      for (int k = 0; k < CDB_W; k++) begin
        if (cdb_rd_en[k]) begin
          if (exp_q.size() == 0) begin
            n_cmp++;
            n_fail++;
            $display("FAIL cdb_unexpected: port %0d got rd=%0d, expected no write", k, cdb_rd[k]);
          end else begin
            mon_e = exp_q.pop_front();
            chk("cdb_port",  64'(k),        64'(mon_e.port));
            chk("cdb_rd",    64'(cdb_rd[k]), 64'(mon_e.rd));
            chk("cdb_value", cdb_value[k],  mon_e.value);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    fu_done            = '0;
    fu_has_dest        = '0;
    br_branch_resolved = 1'b0;
    br_pred_wrong      = 1'b0;
    br_bs_ptr          = '0;
  endtask

  task automatic done(input int j, input int rd, input logic [63:0] v, input logic [3:0] bm);
    fu_done[j]     = 1'b1;
    fu_has_dest[j] = 1'b1;
    fu_rd[j]       = PHYS_REG'(rd);
    fu_value[j]    = v;
    fu_bmask[j]    = bm;
  endtask

  task automatic push(input int port, input int rd, input logic [63:0] v);
    exp_t e;
    e.port  = port;
    e.rd    = PHYS_REG'(rd);
    e.value = v;
    exp_q.push_back(e);
  endtask

  task automatic do_reset();
    idle();
    fu_inflight = '0;
    step();
    reset = 1'b1;
    step();
    step();
    reset = 1'b0;
  endtask

  initial begin
    reset       = 1'b1;
    fu_rd       = '0;
    fu_value    = '0;
    fu_bmask    = '0;
    idle();
    fu_inflight = 7'b0101000;
    step();
    step();
    #1;
    chk("rst_cdb_rd_en", 64'(cdb_rd_en), 64'd0);
    chk("rst_cdb_rd",    64'(cdb_rd),    64'd0);
    chk("rst_cdb_value0", cdb_value[0],  64'd0);
    chk("rst_fu_grant",  64'(fu_grant),  64'd0);
    chk("rst_fub_busy",  64'(fub_busy),  64'(7'b0101000));

    // ALU0 single result
    do_reset();
    done(FU_ALU0, 12, 64'h5, 4'b0);
    push(0, 12, 64'h5);
    #1 chk("s1_busy4_cap", 64'(fub_busy[4]), 64'd0);
    step(); idle();
    #1 chk("s1_grant", 64'(fu_grant), 64'(7'b0010000));
    chk("s1_busy4_grant", 64'(fub_busy[4]), 64'd0);
    step();
    #1 chk("s1_busy4_after", 64'(fub_busy[4]), 64'd0);
    step();
    #1 chk("s1_empty_en", 64'(cdb_rd_en), 64'd0);
    chk("s1_hold_rd",  64'(cdb_rd[0]), 64'd12);
    chk("s1_hold_val", cdb_value[0],   64'h5);

    // slots 0,2,4 then refill of 0 exercises rotation from rr_ptr=3
    do_reset();
    done(0, 1, 64'h11, 4'b0);
    done(2, 2, 64'h22, 4'b0);
    done(4, 3, 64'h33, 4'b0);
    push(0, 1, 64'h11);
    push(1, 2, 64'h22);
    step(); idle();
    done(0, 9, 64'h99, 4'b0);
    #1 chk("s2_grant_a", 64'(fu_grant), 64'(7'b0000101));
    chk("s2_busy4", 64'(fub_busy[4]), 64'd1);
    chk("s2_busy0", 64'(fub_busy[0]), 64'd0);
    push(0, 3, 64'h33);
    push(1, 9, 64'h99);
    step(); idle();
    #1 chk("s2_grant_b", 64'(fu_grant), 64'(7'b0010001));
    step();
    #1 chk("s2_grant_c", 64'(fu_grant), 64'd0);
    chk("s2_busy_c", 64'(fub_busy), 64'd0);

    // all seven complete together
    do_reset();
    for (int j = 0; j < NUM_FU; j++) begin
      done(j, 20 + j, 64'(100 + j), 4'b0);
      push(j % 2, 20 + j, 64'(100 + j));
    end
    step(); idle();
    #1 chk("s3_grant_1", 64'(fu_grant), 64'(7'b0000011));
    chk("s3_busy_1", 64'(fub_busy), 64'(7'b1111100));
    step();
    #1 chk("s3_grant_2", 64'(fu_grant), 64'(7'b0001100));
    step();
    #1 chk("s3_grant_3", 64'(fu_grant), 64'(7'b0110000));
    step();
    #1 chk("s3_grant_4", 64'(fu_grant), 64'(7'b1000000));
    step();
    #1 chk("s3_grant_5", 64'(fu_grant), 64'd0);

    // mispredict squashes slots 1 and 5
    do_reset();
    done(FU_LDST1, 31, 64'h31, 4'b0010);
    done(FU_ALU1,  35, 64'h35, 4'b0010);
    step(); idle();
    br_branch_resolved = 1'b1; br_pred_wrong = 1'b1; br_bs_ptr = 2'd1;
    #1 chk("s4a_grant", 64'(fu_grant), 64'd0);
    chk("s4a_busy", 64'(fub_busy), 64'(7'b0100010));
    step(); idle();
    #1 chk("s4a_busy_after", 64'(fub_busy), 64'd0);
    chk("s4a_grant_after", 64'(fu_grant), 64'd0);
    step();
    step();

    // correct prediction clears the bit at capture
    do_reset();
    done(FU_LDST1, 41, 64'h41, 4'b0010);
    done(FU_ALU1,  45, 64'h45, 4'b0010);
    br_branch_resolved = 1'b1; br_pred_wrong = 1'b0; br_bs_ptr = 2'd1;
    step(); idle();
    br_branch_resolved = 1'b1; br_pred_wrong = 1'b1; br_bs_ptr = 2'd1;
    #1 chk("s4b_grant", 64'(fu_grant), 64'(7'b0100010));
    push(0, 41, 64'h41);
    push(1, 45, 64'h45);
    step(); idle();
    step();

    // correct prediction clears the bit in held slots
    do_reset();
    for (int j = 0; j < NUM_FU; j++) begin
      done(j, 50 + j, 64'(200 + j), 4'b0010);
      push(j % 2, 50 + j, 64'(200 + j));
    end
    step(); idle();
    br_branch_resolved = 1'b1; br_pred_wrong = 1'b0; br_bs_ptr = 2'd1;
    #1 chk("s4c_grant_1", 64'(fu_grant), 64'(7'b0000011));
    step(); idle();
    br_branch_resolved = 1'b1; br_pred_wrong = 1'b1; br_bs_ptr = 2'd1;
    #1 chk("s4c_grant_2", 64'(fu_grant), 64'(7'b0001100));
    step(); idle();
    #1 chk("s4c_grant_3", 64'(fu_grant), 64'(7'b0110000));
    step();
    #1 chk("s4c_grant_4", 64'(fu_grant), 64'(7'b1000000));
    step();

    // inflight multiply and a store with no destination
    do_reset();
    fu_inflight[FU_MULT0] = 1'b1;
    #1 chk("s5_busy_mult", 64'(fub_busy), 64'(7'b0000100));
    fu_done[FU_LDST0] = 1'b1;
    fu_has_dest[FU_LDST0] = 1'b0;
    fu_rd[FU_LDST0] = 6'd7;
    step(); idle();
    #1 chk("s5_busy_store", 64'(fub_busy), 64'(7'b0000100));
    chk("s5_grant", 64'(fu_grant), 64'd0);
    step();
    #1 chk("s5_cdb_en", 64'(cdb_rd_en), 64'd0);
    fu_inflight = '0;

    // capture into a slot that drains at the same edge
    do_reset();
    done(FU_MULT1, 39, 64'hA, 4'b0);
    push(0, 39, 64'hA);
    step(); idle();
    done(FU_MULT1, 40, 64'hB, 4'b0);
    #1 chk("s6_grant_old", 64'(fu_grant), 64'(7'b0001000));
    chk("s6_busy3", 64'(fub_busy[3]), 64'd0);
    push(0, 40, 64'hB);
    step(); idle();
    #1 chk("s6_grant_new", 64'(fu_grant), 64'(7'b0001000));
    step();
    #1 chk("s6_grant_none", 64'(fu_grant), 64'd0);

    step();
    step();
    step();
    chk("queue_empty", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
